// File: rtl/immed_encoder.sv
// Packs a 32-bit immediate into the I/S/B/U/J fields of a template instruction.
// Two-stage valid/ready pipeline with range checks and a saturating error counter.
module immed_encoder #(
    parameter int unsigned ERR_CNT_W = 16,
    parameter bit          CHECK_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_base,
    input  logic [2:0]           in_immedSrc,
    input  logic [31:0]          in_immed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_count
);
    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    logic                 va_q, va_d, vb_q, vb_d;
    logic [31:0]          base_a_q, base_a_d, imm_a_q, imm_a_d;
    logic [2:0]           src_a_q, src_a_d;
    logic [31:0]          inst_b_q, inst_b_d;
    logic                 err_b_q, err_b_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 load_a, load_b;
    logic                 sext11, sext12, sext20, fits;
    logic [31:0]          pack, enc_inst;
    logic                 enc_err;

    always_comb begin
        load_b   = !vb_q || out_ready;
        load_a   = !va_q || load_b;
        in_ready = load_a;
    end

    // Field packing from stage A; fits=0 for illegal formats.
    always_comb begin
        sext11 = (&imm_a_q[31:11]) | ~(|imm_a_q[31:11]);
        sext12 = (&imm_a_q[31:12]) | ~(|imm_a_q[31:12]);
        sext20 = (&imm_a_q[31:20]) | ~(|imm_a_q[31:20]);
        pack   = base_a_q;
        fits   = 1'b0;
        case (src_a_q)
            FMT_I: begin
                pack[31:20] = imm_a_q[11:0];
                fits        = sext11;
            end
            FMT_S: begin
                pack[31:25] = imm_a_q[11:5];
                pack[11:7]  = imm_a_q[4:0];
                fits        = sext11;
            end
            FMT_B: begin
                pack[31]    = imm_a_q[12];
                pack[30:25] = imm_a_q[10:5];
                pack[11:8]  = imm_a_q[4:1];
                pack[7]     = imm_a_q[11];
                fits        = sext12 && !imm_a_q[0];
            end
            FMT_U: begin
                pack[31:12] = imm_a_q[31:12];
                fits        = ~(|imm_a_q[11:0]);
            end
            FMT_J: begin
                pack[31]    = imm_a_q[20];
                pack[30:21] = imm_a_q[10:1];
                pack[20]    = imm_a_q[11];
                pack[19:12] = imm_a_q[19:12];
                fits        = sext20 && !imm_a_q[0];
            end
            default: ;
        endcase
        if (CHECK_EN) begin
            enc_err  = !fits;
            enc_inst = fits ? pack : base_a_q;
        end else begin
            enc_err  = 1'b0;
            enc_inst = pack;
        end
    end

    always_comb begin
        va_d     = va_q;
        base_a_d = base_a_q;
        src_a_d  = src_a_q;
        imm_a_d  = imm_a_q;
        vb_d     = vb_q;
        inst_b_d = inst_b_q;
        err_b_d  = err_b_q;
        cnt_d    = cnt_q;
        if (load_a) begin
            va_d     = in_valid;
            base_a_d = in_base;
            src_a_d  = in_immedSrc;
            imm_a_d  = in_immed;
        end
        if (load_b) begin
            vb_d     = va_q;
            inst_b_d = enc_inst;
            err_b_d  = enc_err;
        end
        if (clr_count) begin
            cnt_d = '0;
        end else if (vb_q && out_ready && err_b_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q     <= 1'b0;
            vb_q     <= 1'b0;
            base_a_q <= '0;
            src_a_q  <= '0;
            imm_a_q  <= '0;
            inst_b_q <= '0;
            err_b_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            va_q     <= va_d;
            vb_q     <= vb_d;
            base_a_q <= base_a_d;
            src_a_q  <= src_a_d;
            imm_a_q  <= imm_a_d;
            inst_b_q <= inst_b_d;
            err_b_q  <= err_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = vb_q;
    assign out_inst  = inst_b_q;
    assign out_err   = err_b_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_immed_encoder.sv
// Randomized and directed bench for immed_encoder against a range/round-trip model.
module tb_immed_encoder;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, clr_count;
    logic [31:0] in_base, in_immed;
    logic [2:0]  in_immedSrc;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_inst;
    logic [15:0] err_count;
    logic        in_ready_nc, out_valid_nc, out_err_nc;
    logic [31:0] out_inst_nc;
    logic [15:0] err_count_nc;
    logic        in_ready_s, out_valid_s, out_err_s;
    logic [31:0] out_inst_s;
    logic [3:0]  err_count_s;

    int unsigned n_tot = 0, n_bad = 0;

    always #5 clk = ~clk;

    immed_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_immedSrc(in_immedSrc), .in_immed(in_immed),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .err_count(err_count), .clr_count(clr_count)
    );

    immed_encoder #(.CHECK_EN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nc),
        .in_base(in_base), .in_immedSrc(in_immedSrc), .in_immed(in_immed),
        .out_valid(out_valid_nc), .out_ready(out_ready), .out_inst(out_inst_nc),
        .out_err(out_err_nc), .err_count(err_count_nc), .clr_count(clr_count)
    );

    immed_encoder #(.ERR_CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_base(in_base), .in_immedSrc(in_immedSrc), .in_immed(in_immed),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_inst(out_inst_s),
        .out_err(out_err_s), .err_count(err_count_s), .clr_count(clr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Representability decided on the signed value; returns {err, inst}.
    function automatic logic [32:0] model(input logic [31:0] b, input logic [2:0] s,
                                          input logic [31:0] im, input bit check);
        int          v  = $signed(im);
        bit          ok = 1'b0;
        logic [31:0] r  = b;
        case (s)
            3'd0: begin ok = (v >= -2048 && v <= 2047); r[31:20] = im[11:0]; end
            3'd1: begin ok = (v >= -2048 && v <= 2047); r[31:25] = im[11:5]; r[11:7] = im[4:0]; end
            3'd2: begin
                ok = (v >= -4096 && v <= 4095) && (v % 2 == 0);
                r[31] = im[12]; r[30:25] = im[10:5]; r[11:8] = im[4:1]; r[7] = im[11];
            end
            3'd3: begin ok = (im % 4096 == 0); r[31:12] = im[31:12]; end
            3'd4: begin
                ok = (v >= -1048576 && v <= 1048575) && (v % 2 == 0);
                r[31] = im[20]; r[30:21] = im[10:1]; r[20] = im[11]; r[19:12] = im[19:12];
            end
            default: ok = 1'b0;
        endcase
        if (!check) return {1'b0, r};
        if (!ok)    return {1'b1, b};
        return {1'b0, r};
    endfunction

    function automatic logic [31:0] immed_gen(input logic [31:0] i, input logic [2:0] s);
        case (s)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    typedef struct {
        logic [31:0] base;
        logic [2:0]  src;
        logic [31:0] imm;
    } beat_t;
    beat_t       sbq[$];
    beat_t       sb;
    int unsigned mcnt = 0, scnt = 0;
    bit          started = 1'b0, hs_err;
    logic [32:0] e, en;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            mcnt    = 0;
            scnt    = 0;
            started = 1'b1;
        end else if (started) begin
            chk("cnt", 32'(err_count), mcnt);
            chk("cnt_s", 32'(err_count_s), scnt);
            hs_err = 1'b0;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_under", 32'(sbq.size()), 32'd1);
                end else begin
                    sb = sbq.pop_front();
                    e  = model(sb.base, sb.src, sb.imm, 1'b1);
                    en = model(sb.base, sb.src, sb.imm, 1'b0);
                    chk("inst", out_inst, e[31:0]);
                    chk("err", 32'(out_err), 32'(e[32]));
                    chk("nc_inst", out_inst_nc, en[31:0]);
                    chk("nc_err", 32'(out_err_nc), 32'(en[32]));
                    chk("s_err", 32'(out_err_s), 32'(e[32]));
                    if (!e[32]) chk("rtrip", immed_gen(out_inst, sb.src), sb.imm);
                    hs_err = e[32];
                end
            end
            if (in_valid && in_ready) sbq.push_back('{in_base, in_immedSrc, in_immed});
            if (clr_count) begin
                mcnt = 0;
                scnt = 0;
            end else if (hs_err) begin
                if (mcnt < 65535) mcnt++;
                if (scnt < 15) scnt++;
            end
        end
    end

    task automatic send(input logic [31:0] b, input logic [2:0] s, input logic [31:0] im);
        int unsigned t = 0;
        in_base = b; in_immedSrc = s; in_immed = im; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] inst, input logic err);
        int unsigned t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin @(negedge clk); t++; end
        chk({tag, "_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, out_inst, inst);
        chk({tag, "_err"}, 32'(out_err), 32'(err));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_imm();
        int v;
        case ($urandom % 5)
            0:       v = int'($urandom);
            1:       v = int'($urandom_range(0, 4095)) - 2048;
            2:       v = int'($urandom_range(0, 8191)) - 4096;
            3:       v = int'($urandom & 32'hFFFFF000);
            default: v = int'($urandom_range(0, 2097151)) - 1048576;
        endcase
        return v;
    endfunction

    logic [31:0] bp_exp [3];

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=%h exp=%h", 32'd0, 32'd1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_base = '0; in_immedSrc = '0; in_immed = '0;
        out_ready = 1'b1; clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        send(32'h00000093, 3'd0, 32'hFFFFFFFF);
        @(negedge clk); chk("lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat2_valid", 32'(out_valid), 32'd1);
        chk("i_inst", out_inst, 32'hFFF00093);
        chk("i_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;

        send(32'h0020A023, 3'd1, 32'd8);         expect_out("s", 32'h0020A423, 1'b0);
        send(32'h00000037, 3'd3, 32'h12345000);  expect_out("u", 32'h12345037, 1'b0);
        send(32'h00000063, 3'd2, 32'hFFFFFFFC);  expect_out("b", 32'hFE000EE3, 1'b0);
        send(32'h0000006F, 3'd4, 32'd3);         expect_out("j_odd", 32'h0000006F, 1'b1);

        clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        chk("clr", 32'(err_count), 32'd0);
        send(32'h00000013, 3'd0, 32'd2048);      expect_out("i_rng", 32'h00000013, 1'b1);
        chk("cnt1", 32'(err_count), 32'd1);
        send(32'h00000033, 3'd6, 32'd0);         expect_out("src6", 32'h00000033, 1'b1);
        chk("cnt2", 32'(err_count), 32'd2);

        // Clear coincides with the delivery of an error beat.
        send(32'h00000013, 3'd0, 32'd4096);
        @(posedge clk); #1;
        clr_count = 1'b1;
        chk("clrhs_valid", 32'(out_valid), 32'd1);
        chk("clrhs_err", 32'(out_err), 32'd1);
        @(posedge clk); #1 clr_count = 1'b0;
        chk("clrhs_cnt", 32'(err_count), 32'd0);

        bp_exp[0] = 32'h00100013; bp_exp[1] = 32'h00200013; bp_exp[2] = 32'h00300013;
        out_ready = 1'b0;
        begin
            int unsigned acc = 0;
            for (int c = 0; c < 4; c++) begin
                in_valid = 1'b1; in_base = 32'h13; in_immedSrc = 3'd0; in_immed = acc + 1;
                @(negedge clk);
                if (in_ready) acc++;
                @(posedge clk); #1;
            end
            chk("bp_accepted", acc, 32'd2);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_v", 32'(out_valid), 32'd1);
            chk("bp_hold_inst", out_inst, bp_exp[0]);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_drain_v", 32'(out_valid), 32'd1);
            chk("bp_drain_inst", out_inst, bp_exp[c]);
            @(posedge clk); #1;
            if (c == 0) in_valid = 1'b0;
        end

        for (int k = 0; k < 20; k++) send($urandom, 3'd7, $urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_main", 32'(err_count), 32'd20);
        chk("sat_small", 32'(err_count_s), 32'd15);
        send(32'h13, 3'd5, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_main2", 32'(err_count), 32'd21);
        chk("sat_hold", 32'(err_count_s), 32'd15);

        out_ready = 1'b0;
        send(32'h13, 3'd0, 32'd5);
        send(32'h13, 3'd5, 32'd5);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_cnt", 32'(err_count), 32'd0);
        chk("mrst_inst", out_inst, 32'd0);
        out_ready = 1'b1;

        begin
            int unsigned sent = 0, guard = 0;
            bit acc;
            while (sent < 10000 && guard < 60000) begin
                guard++;
                if (!in_valid && ($urandom % 4 != 0)) begin
                    in_base     = $urandom;
                    in_immedSrc = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                    in_immed    = rnd_imm();
                    in_valid    = 1'b1;
                end
                out_ready = ($urandom % 4) != 0;
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc) begin
                    in_valid = 1'b0;
                    sent++;
                end
            end
            chk("rand_sent", sent, 32'd10000);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
